encrypt: RTL and testbench
==========================

ENCRYPT -- requirements
Module: encrypt

Interface
REQ-001 Parameters: PLAINTEXT_MODULUS, default 64, plaintext modulus p.
REQ-002 PLAINTEXT_WIDTH, default 6, log2(p).
REQ-003 CIPHERTEXT_MODULUS, default 1024, ciphertext modulus q, a power of two.
REQ-004 CIPHERTEXT_WIDTH, default 10, log2(q).
REQ-005 DIMENSION, default 10, secret length n; ciphertext has n+1 entries.
REQ-006 BIG_N, default 30, number of public-key rows.
REQ-007 SCALE_SHIFT, default CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH, left shift applied to plaintext before it is added.
REQ-008 Reset is rst_n, synchronous, active-low; the clock is clk.
REQ-009 Ports: clk  in  1  clock.
REQ-010 rst_n  in  1  synchronous active-low reset.
REQ-011 start  in  1  request an encryption; sampled only in IDLE.
REQ-012 plaintext  in  PLAINTEXT_WIDTH  message m; latched on an accepted start.
REQ-013 subset  in  BIG_N  random row-select vector; latched on an accepted start.
REQ-014 pk_row  out  clog2(BIG_N)  public-key row address.
REQ-015 pk_col  out  clog2(DIMENSION+1)  public-key column address.
REQ-016 pk_entry  in  CIPHERTEXT_WIDTH  public-key entry at (pk_row, pk_col), valid in the same cycle (combinational read).
REQ-017 ct_entry  out  CIPHERTEXT_WIDTH  ciphertext entry.
REQ-018 ct_index  out  clog2(DIMENSION+1)  index of ct_entry.
REQ-019 ct_valid  out  1  ct_entry is valid.
REQ-020 ct_ready  in  1  downstream accepts the entry.
REQ-021 busy  out  1  high in any state other than IDLE.
REQ-022 done  out  1  one-cycle pulse on completion.

Function
REQ-023 Operation: ct[j] = (sum over i with subset[i]=1 of PK[i][j]) mod q for j = 0..DIMENSION; ct[DIMENSION] additionally gets + (m << SCALE_SHIFT) mod q.
REQ-024 FSM states: IDLE, ACCUM, EMIT, DONE.
REQ-025 Transitions: IDLE->ACCUM on start; ACCUM->EMIT after row BIG_N-1; EMIT->ACCUM on handshake when column < DIMENSION; EMIT->DONE on handshake at column DIMENSION; DONE->IDLE unconditionally.
REQ-026 ACCUM processes one row per cycle, row 0..BIG_N-1, at the current column; the accumulator is cleared on entering ACCUM for each column.
REQ-027 In ACCUM, the accumulator adds pk_entry only when the latched subset[pk_row] = 1; otherwise it holds.
REQ-028 Arithmetic is CIPHERTEXT_WIDTH bits; wrap-around is modulo q by truncation, with no saturation.
REQ-029 The plaintext term is added in the last ACCUM cycle of column DIMENSION and no other column.
REQ-030 EMIT: ct_valid=1, ct_index=column, and ct_entry=accumulator.
REQ-031 A handshake occurs when ct_valid and ct_ready are both 1 on a clock edge.
REQ-032 While ct_ready=0, ct_entry and ct_index hold stable and the FSM stalls.
REQ-033 Latency with ct_ready held at 1: start sampled at cycle 0 gives the first ct_valid at cycle BIG_N+1.
REQ-034 Each further column takes BIG_N+1 cycles, and done is asserted one cycle after the final handshake: cycle (DIMENSION+1)*(BIG_N+1)+1.
REQ-035 A start asserted while busy=1 is ignored, and the latched plaintext and subset are not changed.
REQ-036 pk_row and pk_col are 0 outside ACCUM.

Reset
REQ-037 While rst_n=0 at a clock edge, the block SHALL enter IDLE and clear the accumulator, latched registers, row and column counters, ct_valid, done and busy; ct_entry and ct_index SHALL be 0.
REQ-038 A reset asserted mid-operation SHALL abort the operation with no partial done pulse, and the next start SHALL restart at column 0.

Verification (default parameters)
REQ-039 subset=0, m=5, ct_ready=1 -> ct[0..9]=0, ct[10]=80, done pulse 342 cycles after start.
REQ-040 All pk_entry=1, subset all ones, m=0 -> every ct[j]=30.
REQ-041 pk_entry=1000 everywhere, subset bits 0 and 1 set, m=63 -> ct[0..9]=976 and ct[10]=960 (mod 1024 wrap).
REQ-042 ct_ready low for 5 cycles during ct_index=3 -> ct_entry/ct_index stable throughout, one handshake only, done delayed by exactly 5 cycles.
REQ-043 rst_n low for 1 cycle during ACCUM of column 4 -> busy=0, ct_valid=0, no done pulse; a new start yields correct ct from index 0.
REQ-044 start pulsed with different plaintext while busy -> ignored; outputs match the originally latched plaintext.

Source files
------------

// File: rtl/encrypt.sv
// Public-key encryption engine: sums the subset-selected public-key rows column by
// column, adds the scaled plaintext to the last column and streams each entry out.
module encrypt #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 10,
  parameter int BIG_N              = 30,
  parameter int SCALE_SHIFT        = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [PLAINTEXT_WIDTH-1:0]           plaintext,
  input  logic [BIG_N-1:0]                     subset,
  output logic [$clog2(BIG_N)-1:0]             pk_row,
  output logic [$clog2(DIMENSION+1)-1:0]       pk_col,
  input  logic [CIPHERTEXT_WIDTH-1:0]          pk_entry,
  output logic [CIPHERTEXT_WIDTH-1:0]          ct_entry,
  output logic [$clog2(DIMENSION+1)-1:0]       ct_index,
  output logic                                 ct_valid,
  input  logic                                 ct_ready,
  output logic                                 busy,
  output logic                                 done
);

  localparam int ROW_W = $clog2(BIG_N);
  localparam int COL_W = $clog2(DIMENSION + 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BIG_N - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(DIMENSION);
  // Both moduli are powers of two, so reduction is a mask.
  localparam logic [CIPHERTEXT_WIDTH-1:0] CT_MASK = CIPHERTEXT_WIDTH'(CIPHERTEXT_MODULUS - 1);
  localparam logic [PLAINTEXT_WIDTH-1:0]  PT_MASK = PLAINTEXT_WIDTH'(PLAINTEXT_MODULUS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_e;

  state_e                        state_q, state_d;
  logic [CIPHERTEXT_WIDTH-1:0]   acc_q, acc_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic [PLAINTEXT_WIDTH-1:0]    pt_q, pt_d;
  logic [BIG_N-1:0]              sub_q, sub_d;
  logic [CIPHERTEXT_WIDTH-1:0]   pt_scaled;
  logic [CIPHERTEXT_WIDTH-1:0]   pk_term;
  logic [CIPHERTEXT_WIDTH-1:0]   pt_term;

  assign pt_scaled = CIPHERTEXT_WIDTH'(pt_q) << SCALE_SHIFT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      pt_q    <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pt_q    <= pt_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    row_d    = row_q;
    col_d    = col_q;
    pt_d     = pt_q;
    sub_d    = sub_q;
    pk_term  = '0;
    pt_term  = '0;
    pk_row   = '0;
    pk_col   = '0;
    ct_entry = '0;
    ct_index = '0;
    ct_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          pt_d    = plaintext & PT_MASK;
          sub_d   = subset;
        end
      end
      ACCUM: begin
        busy   = 1'b1;
        pk_row = row_q;
        pk_col = col_q;
        if (sub_q[row_q]) pk_term = pk_entry;
        // Message term joins only the final row of the final column.
        if (row_q == LAST_ROW && col_q == LAST_COL) pt_term = pt_scaled;
        acc_d = (acc_q + pk_term + pt_term) & CT_MASK;
        if (row_q == LAST_ROW) begin
          state_d = EMIT;
          row_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      EMIT: begin
        busy     = 1'b1;
        ct_valid = 1'b1;
        ct_entry = acc_q;
        ct_index = col_q;
        if (ct_ready) begin
          if (col_q == LAST_COL) begin
            state_d = DONE;
          end else begin
            state_d = ACCUM;
            col_d   = col_q + 1'b1;
            acc_d   = '0;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
        col_d   = '0;
        acc_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encrypt.sv
// Directed bench for encrypt: drives a behavioural public-key table and checks
// ciphertext entries, done timing, back-pressure, abort and ignored starts.
module tb_encrypt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  plaintext;
  logic [29:0] subset;
  logic [4:0]  pk_row;
  logic [3:0]  pk_col;
  logic [9:0]  pk_entry;
  logic [9:0]  ct_entry;
  logic [3:0]  ct_index;
  logic        ct_valid;
  logic        ct_ready;
  logic        busy;
  logic        done;

  logic [9:0]  pk_mem [0:29][0:10];
  int          ct_got [0:10];
  int          exp_ct [0:10];
  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          hs_cnt, unstable_cnt, first_idx, done_cnt;

  always #5 clk = ~clk;

  assign pk_entry = (pk_row < 5'd30 && pk_col < 4'd11) ? pk_mem[pk_row][pk_col] : 10'd0;

  encrypt dut (
    .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext), .subset(subset),
    .pk_row(pk_row), .pk_col(pk_col), .pk_entry(pk_entry),
    .ct_entry(ct_entry), .ct_index(ct_index), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_pk(input bit rnd, input logic [9:0] val);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 11; c++)
        pk_mem[r][c] = rnd ? 10'($urandom_range(0, 1023)) : val;
  endtask

  // Runs one encryption. stall_idx/stall_len hold ct_ready low at that index;
  // inj_cyc re-pulses start while busy; abort_cyc pulses reset for one cycle.
  task automatic run_enc(input logic [5:0] m, input logic [29:0] sub,
                         input int stall_idx, input int stall_len,
                         input int inj_cyc, input int abort_cyc, output int done_cyc);
    int cyc, stalled;
    logic [9:0] hold_e;
    logic [3:0] hold_i;
    bit aborted;
    cyc = 0; stalled = 0; aborted = 0; done_cyc = -1;
    hs_cnt = 0; unstable_cnt = 0; first_idx = -1; done_cnt = 0;
    hold_e = '0; hold_i = '0;
    for (int j = 0; j < 11; j++) ct_got[j] = -1;
    @(negedge clk);
    start = 1'b1; plaintext = m; subset = sub; ct_ready = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; plaintext = ~m; subset = ~sub;
      end
      if (cyc == inj_cyc) begin
        check("inj_busy", busy, 1);
        start = 1'b1; plaintext = m ^ 6'h2a; subset = ~sub;
      end else if (cyc == inj_cyc + 1) begin
        start = 1'b0;
      end
      if (cyc == abort_cyc) rst_n = 1'b0;
      if (cyc == abort_cyc + 1) begin
        rst_n = 1'b1;
        aborted = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_valid", ct_valid, 0);
        check("abort_index", ct_index, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
      if (ct_valid && ct_index == 4'(stall_idx) && stalled < stall_len) begin
        if (stalled == 0) begin
          hold_e = ct_entry; hold_i = ct_index;
        end else if (ct_entry !== hold_e || ct_index !== hold_i) begin
          unstable_cnt++;
        end
        ct_ready = 1'b0;
        stalled++;
      end else begin
        ct_ready = 1'b1;
      end
      if (ct_valid && ct_ready) begin
        if (stall_len > 0 && ct_index == 4'(stall_idx) && ct_entry !== hold_e) unstable_cnt++;
        ct_got[ct_index] = int'(ct_entry);
        if (hs_cnt == 0) first_idx = int'(ct_index);
        hs_cnt++;
      end
      if (aborted && cyc > abort_cyc + 400) break;
      if (cyc > 3000) begin
        check("done_timeout", done_cnt, 1);
        break;
      end
    end
    ct_ready = 1'b1;
  endtask

  task automatic check_ct(input string tag);
    for (int j = 0; j < 11; j++) check($sformatf("%s_ct%0d", tag, j), ct_got[j], exp_ct[j]);
  endtask

  initial begin
    int dc;
    logic [5:0]  rm;
    logic [29:0] rs;
    rst_n = 1'b0; start = 1'b0; plaintext = '0; subset = '0; ct_ready = 1'b1;
    fill_pk(1'b1, '0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", ct_valid, 0);
    check("rst_done", done, 0);
    check("rst_entry", ct_entry, 0);
    check("rst_index", ct_index, 0);
    check("rst_pk_row", pk_row, 0);
    check("rst_pk_col", pk_col, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty subset: only the scaled message survives (5 << 4 = 80).
    run_enc(6'd5, 30'd0, -1, 0, -1, -1, dc);
    for (int j = 0; j < 10; j++) exp_ct[j] = 0;
    exp_ct[10] = 80;
    check_ct("zero_sub");
    check("zero_sub_done_cyc", dc, 342);
    check("zero_sub_hs", hs_cnt, 11);
    check("zero_sub_first", first_idx, 0);
    @(negedge clk);
    check("done_pulse_len", done, 0);
    check("idle_busy", busy, 0);

    // All ones: every column sums 30 rows of 1.
    fill_pk(1'b0, 10'd1);
    run_enc(6'd0, '1, -1, 0, -1, -1, dc);
    for (int j = 0; j < 11; j++) exp_ct[j] = 30;
    check_ct("ones");

    // Wrap: 2*1000 = 2000 -> 976; plus 63<<4 = 1008 -> 1984 -> 960.
    fill_pk(1'b0, 10'd1000);
    run_enc(6'd63, 30'h3, -1, 0, -1, -1, dc);
    for (int j = 0; j < 10; j++) exp_ct[j] = 976;
    exp_ct[10] = 960;
    check_ct("wrap");
    check("wrap_done_cyc", dc, 342);

    // Back-pressure at index 3 for 5 cycles.
    run_enc(6'd63, 30'h3, 3, 5, -1, -1, dc);
    check_ct("stall");
    check("stall_done_cyc", dc, 347);
    check("stall_hs", hs_cnt, 11);
    check("stall_stable", unstable_cnt, 0);

    // Reset in column 4 accumulation (cycles 125..154), then a clean restart.
    fill_pk(1'b0, 10'd1);
    run_enc(6'd7, '1, -1, 0, -1, 130, dc);
    check("abort_no_done", done_cnt, 0);
    run_enc(6'd7, '1, -1, 0, -1, -1, dc);
    for (int j = 0; j < 10; j++) exp_ct[j] = 30;
    exp_ct[10] = 142;
    check_ct("restart");
    check("restart_first", first_idx, 0);
    check("restart_done_cyc", dc, 342);

    // Start while busy with a different message: must be ignored (30 + 2<<4 = 62).
    run_enc(6'd2, '1, -1, 0, 50, -1, dc);
    for (int j = 0; j < 10; j++) exp_ct[j] = 30;
    exp_ct[10] = 62;
    check_ct("busy_start");
    check("busy_start_done_cyc", dc, 342);

    // Random table, subset and message against a reference sum.
    fill_pk(1'b1, '0);
    rm = 6'($urandom_range(0, 63));
    rs = 30'($urandom);
    for (int j = 0; j < 11; j++) begin
      logic [9:0] s;
      s = '0;
      for (int r = 0; r < 30; r++) if (rs[r]) s = s + pk_mem[r][j];
      if (j == 10) s = s + {rm, 4'b0000};
      exp_ct[j] = int'(s);
    end
    run_enc(rm, rs, -1, 0, -1, -1, dc);
    check_ct("random");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
